// File: rtl/noc_local_ni.sv
// Local-port NI: packetizes core sends into 40-bit flits, injects them, and queues ejected flits.
// Latency: TX accept->ni_valid_out 2 cycles, RX capture->rx_valid 1 cycle; injection honours router occupancy, RX drops on full queue.
module noc_local_ni #(
    parameter int DEPTH               = 8,
    parameter int WIDTH               = 3,
    parameter int DATASIZE            = 40,
    parameter logic [3:0] NODE_ID     = 4'd0,
    parameter int TXDEPTH             = 4,
    parameter int RXDEPTH             = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_req,
    input  logic [3:0]          tx_dst,
    input  logic [21:0]         tx_data,
    input  logic [1:0]          tx_type,
    output logic                tx_ready,
    output logic [DATASIZE-1:0] ni_data_out,
    output logic                ni_valid_out,
    input  logic                router_full,
    input  logic [WIDTH:0]      router_press,
    input  logic [DATASIZE-1:0] ni_data_in,
    input  logic                ni_valid_in,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [3:0]          rx_src,
    output logic [21:0]         rx_data,
    output logic [1:0]          rx_type,
    output logic [7:0]          rx_latency,
    output logic [2:0]          err_flags,
    output logic [15:0]         tx_count,
    output logic [15:0]         rx_count
);
    localparam int TXAW = $clog2(TXDEPTH);
    localparam int RXAW = $clog2(RXDEPTH);
    localparam logic [TXAW:0]    TX_FULL  = (TXAW+1)'(TXDEPTH);
    localparam logic [RXAW:0]    RX_FULL  = (RXAW+1)'(RXDEPTH);
    localparam logic [WIDTH+1:0] DEPTH_W  = (WIDTH+2)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND} state_t;

    typedef struct packed {
        logic [3:0]  src;
        logic [21:0] data;
        logic [1:0]  kind;
        logic [7:0]  lat;
    } rx_entry_t;

    state_t                state;
    logic [7:0]            ts;
    logic [DATASIZE-1:0]   tx_mem [TXDEPTH];
    logic [TXAW-1:0]       tx_wp, tx_rp;
    logic [TXAW:0]         tx_cnt;
    rx_entry_t             rx_mem [RXDEPTH];
    logic [RXAW-1:0]       rx_wp, rx_rp;
    logic [RXAW:0]         rx_cnt;

    logic tx_empty, tx_push, self_send, space, issue;
    logic rx_full, rx_pop, rx_hit, rx_push, misroute, overflow;
    logic [WIDTH+1:0] press_sum;
    logic [7:0] rx_lat;

    assign tx_empty  = (tx_cnt == '0);
    assign tx_ready  = (tx_cnt != TX_FULL);
    assign tx_push   = tx_req && tx_ready && (tx_dst != NODE_ID);
    assign self_send = tx_req && tx_ready && (tx_dst == NODE_ID);

    // A flit on the wire this cycle is not yet reflected in router_press.
    assign press_sum = {1'b0, router_press} + (WIDTH+2)'(state == ST_SEND);
    assign space     = !router_full && (press_sum < DEPTH_W);
    assign issue     = (state != ST_IDLE) && !tx_empty && space;

    assign rx_valid  = (rx_cnt != '0);
    assign rx_full   = (rx_cnt == RX_FULL);
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_hit    = ni_valid_in && (ni_data_in[35:32] == NODE_ID);
    assign misroute  = ni_valid_in && (ni_data_in[35:32] != NODE_ID);
    assign rx_push   = rx_hit && (!rx_full || rx_pop);
    assign overflow  = rx_hit && rx_full && !rx_pop;
    assign rx_lat    = ts - ni_data_in[31:24];

    assign rx_src     = rx_mem[rx_rp].src;
    assign rx_data    = rx_mem[rx_rp].data;
    assign rx_type    = rx_mem[rx_rp].kind;
    assign rx_latency = rx_mem[rx_rp].lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts        <= '0;
            err_flags <= '0;
        end else begin
            ts        <= ts + 8'd1;
            err_flags <= err_flags | {misroute, overflow, self_send};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            for (int i = 0; i < TXDEPTH; i++) tx_mem[i] <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wp] <= {NODE_ID, tx_dst, ts, tx_data, tx_type};
                tx_wp         <= tx_wp + 1'b1;
            end
            if (issue) tx_rp <= tx_rp + 1'b1;
            if (tx_push && !issue)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && issue) tx_cnt <= tx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ni_valid_out <= 1'b0;
            ni_data_out  <= '0;
            tx_count     <= '0;
        end else begin
            if (issue) begin
                state        <= ST_SEND;
                ni_valid_out <= 1'b1;
                ni_data_out  <= tx_mem[tx_rp];
                if (tx_count != 16'hFFFF) tx_count <= tx_count + 16'd1;
            end else begin
                state        <= tx_empty ? ST_IDLE : ST_WAIT;
                ni_valid_out <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_cnt   <= '0;
            rx_count <= '0;
            for (int i = 0; i < RXDEPTH; i++) rx_mem[i] <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wp] <= '{src: ni_data_in[39:36], data: ni_data_in[23:2],
                                   kind: ni_data_in[1:0], lat: rx_lat};
                rx_wp         <= rx_wp + 1'b1;
                if (rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
            end
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni with NODE_ID=0 and a simple router occupancy model.
module tb_noc_local_ni;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tx_req = 1'b0;
    logic [3:0]  tx_dst = '0;
    logic [21:0] tx_data = '0;
    logic [1:0]  tx_type = '0;
    logic        tx_ready;
    logic [39:0] ni_data_out;
    logic        ni_valid_out;
    logic        router_full = 1'b0;
    logic [3:0]  router_press = '0;
    logic [39:0] ni_data_in = '0;
    logic        ni_valid_in = 1'b0;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [3:0]  rx_src;
    logic [21:0] rx_data;
    logic [1:0]  rx_type;
    logic [7:0]  rx_latency;
    logic [2:0]  err_flags;
    logic [15:0] tx_count;
    logic [15:0] rx_count;

    int tests = 0;
    int fails = 0;
    logic [7:0] tb_ts;

    noc_local_ni #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .NODE_ID(4'd0), .TXDEPTH(4), .RXDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_dst(tx_dst), .tx_data(tx_data),
        .tx_type(tx_type), .tx_ready(tx_ready), .ni_data_out(ni_data_out), .ni_valid_out(ni_valid_out),
        .router_full(router_full), .router_press(router_press), .ni_data_in(ni_data_in),
        .ni_valid_in(ni_valid_in), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src),
        .rx_data(rx_data), .rx_type(rx_type), .rx_latency(rx_latency), .err_flags(err_flags),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    // Reference tick: zero out of reset, +1 per rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 8'd0;
        else        tb_ts <= tb_ts + 8'd1;
    end

    task automatic push(input logic [3:0] d, input logic [21:0] dat, input logic [1:0] ty);
        tx_req = 1'b1; tx_dst = d; tx_data = dat; tx_type = ty;
        @(negedge clk);
        tx_req = 1'b0;
    endtask

    task automatic send_rx(input logic [3:0] s, input logic [3:0] d, input logic [7:0] t, input logic [21:0] dat);
        ni_valid_in = 1'b1;
        ni_data_in  = {s, d, t, dat, 2'd2};
        @(negedge clk);
        ni_valid_in = 1'b0;
    endtask

    task automatic wait_ts(input logic [7:0] target);
        for (int i = 0; i < 300 && tb_ts != target; i++) @(negedge clk);
        tests++;
        if (tb_ts !== target) begin fails++; $display("FAIL wait_ts: got %0d want %0d", tb_ts, target); end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (ni_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid_out: got %b want 0", ni_valid_out); end
        tests++; if (ni_data_out !== 40'h0) begin fails++; $display("FAIL reset_data_out: got %h want 0", ni_data_out); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests++; if (err_flags !== 3'b000) begin fails++; $display("FAIL reset_err: got %b want 000", err_flags); end
        tests++; if (tx_count !== 16'd0) begin fails++; $display("FAIL reset_tx_count: got %0d want 0", tx_count); end
        tests++; if (rx_count !== 16'd0) begin fails++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_tx_basic;
        router_press = 4'd0; router_full = 1'b0;
        wait_ts(8'd10);
        push(4'd3, 22'h155, 2'd1);
        tests++; if (ni_valid_out !== 1'b0) begin fails++; $display("FAIL tx_lat1: got %b want 0", ni_valid_out); end
        @(negedge clk);
        tests++; if (ni_valid_out !== 1'b0) begin fails++; $display("FAIL tx_lat2: got %b want 0", ni_valid_out); end
        @(negedge clk);
        tests++; if (ni_valid_out !== 1'b1) begin fails++; $display("FAIL tx_valid: got %b want 1", ni_valid_out); end
        tests++; if (ni_data_out !== 40'h030A000555) begin fails++; $display("FAIL tx_flit: got %h want 030a000555", ni_data_out); end
        @(negedge clk);
        tests++; if (ni_valid_out !== 1'b0) begin fails++; $display("FAIL tx_one_cycle: got %b want 0", ni_valid_out); end
        tests++; if (tx_count !== 16'd1) begin fails++; $display("FAIL tx_count1: got %0d want 1", tx_count); end
    endtask

    task automatic test_back_to_back;
        logic [5:0]  v;
        logic [39:0] d2;
        v = '0; d2 = '0;
        for (int i = 1; i <= 3; i++) push(4'(i), 22'(i), 2'd0);
        v[0] = ni_valid_out;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            v[k] = ni_valid_out;
            if (k == 1) d2 = ni_data_out;
        end
        tests++; if (v !== 6'b000111) begin fails++; $display("FAIL b2b_pattern: got %b want 000111", v); end
        tests++; if (d2[35:32] !== 4'd2 || d2[23:2] !== 22'd2) begin fails++; $display("FAIL b2b_order: got %h want dst 2 data 2", d2); end
        tests++; if (tx_count !== 16'd4) begin fails++; $display("FAIL b2b_count: got %0d want 4", tx_count); end
    endtask

    task automatic observe(input int cycles, output int sent, output logic [39:0] first);
        sent = 0; first = '0;
        for (int i = 0; i < cycles; i++) begin
            if (ni_valid_out) begin
                if (sent == 0) first = ni_data_out;
                sent++;
                @(posedge clk);
                #1 router_press = router_press + 4'd1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pressure;
        int sent;
        logic [39:0] first;
        router_press = 4'd7;
        for (int i = 1; i <= 3; i++) push(4'(i), 22'h10 + 22'(i), 2'd1);
        observe(14, sent, first);
        tests++; if (sent !== 1) begin fails++; $display("FAIL press_blocked_sent: got %0d want 1", sent); end
        tests++; if (first[35:32] !== 4'd1) begin fails++; $display("FAIL press_first_dst: got %0d want 1", first[35:32]); end
        tests++; if (tx_count !== 16'd5) begin fails++; $display("FAIL press_count: got %0d want 5", tx_count); end
        router_press = 4'd5;
        @(negedge clk);
        observe(10, sent, first);
        tests++; if (sent !== 2) begin fails++; $display("FAIL press_drain_sent: got %0d want 2", sent); end
        tests++; if (router_press !== 4'd7) begin fails++; $display("FAIL press_final: got %0d want 7", router_press); end
        tests++; if (tx_count !== 16'd7) begin fails++; $display("FAIL press_count2: got %0d want 7", tx_count); end
        router_press = 4'd0;
    endtask

    task automatic test_rx;
        rx_ready = 1'b0;
        wait_ts(8'd4);
        ni_valid_in = 1'b1;
        ni_data_in  = {4'd5, 4'd0, 8'd250, 22'h2ABCD, 2'd3};
        @(negedge clk);
        ni_valid_in = 1'b0;
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL rx_valid: got %b want 1", rx_valid); end
        tests++; if (rx_src !== 4'd5) begin fails++; $display("FAIL rx_src: got %0d want 5", rx_src); end
        tests++; if (rx_data !== 22'h2ABCD) begin fails++; $display("FAIL rx_data: got %h want 2abcd", rx_data); end
        tests++; if (rx_type !== 2'd3) begin fails++; $display("FAIL rx_type: got %0d want 3", rx_type); end
        tests++; if (rx_latency !== 8'd10) begin fails++; $display("FAIL rx_latency: got %0d want 10", rx_latency); end
        tests++; if (rx_count !== 16'd1) begin fails++; $display("FAIL rx_count1: got %0d want 1", rx_count); end
        @(negedge clk);
        tests++; if (rx_latency !== 8'd10 || rx_valid !== 1'b1) begin fails++; $display("FAIL rx_hold: got lat %0d valid %b want 10 1", rx_latency, rx_valid); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rx_pop: got %b want 0", rx_valid); end
    endtask

    task automatic test_rx_overflow;
        int n;
        logic [3:0] last;
        for (int i = 1; i <= 4; i++) send_rx(4'(i), 4'd0, 8'd0, 22'(i));
        send_rx(4'd7, 4'd0, 8'd0, 22'h7);
        send_rx(4'd8, 4'd0, 8'd0, 22'h8);
        tests++; if (rx_count !== 16'd5) begin fails++; $display("FAIL ovf_count: got %0d want 5", rx_count); end
        tests++; if (err_flags !== 3'b010) begin fails++; $display("FAIL ovf_err: got %b want 010", err_flags); end
        tests++; if (rx_src !== 4'd1) begin fails++; $display("FAIL ovf_head: got %0d want 1", rx_src); end
        rx_ready = 1'b1;
        send_rx(4'd9, 4'd0, 8'd0, 22'h9);
        rx_ready = 1'b0;
        tests++; if (rx_count !== 16'd6) begin fails++; $display("FAIL ovf_pop_accept: got %0d want 6", rx_count); end
        n = 0; last = '0;
        while (rx_valid && n < 10) begin
            last = rx_src;
            rx_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        rx_ready = 1'b0;
        tests++; if (n !== 4 || last !== 4'd9) begin fails++; $display("FAIL ovf_drain: got %0d entries last src %0d want 4 entries last src 9", n, last); end
    endtask

    task automatic test_errors;
        int seen;
        seen = 0;
        push(4'd0, 22'h3, 2'd1);
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL self_ready: got %b want 1", tx_ready); end
        for (int i = 0; i < 6; i++) begin
            if (ni_valid_out) seen++;
            @(negedge clk);
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL self_injected: got %0d flits want 0", seen); end
        tests++; if (err_flags !== 3'b011) begin fails++; $display("FAIL self_err: got %b want 011", err_flags); end
        send_rx(4'd5, 4'd2, 8'd0, 22'h1);
        tests++; if (err_flags !== 3'b111) begin fails++; $display("FAIL misroute_err: got %b want 111", err_flags); end
        tests++; if (rx_valid !== 1'b0 || rx_count !== 16'd6) begin fails++; $display("FAIL misroute_drop: got valid %b count %0d want 0 6", rx_valid, rx_count); end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        router_full = 1'b1;
        for (int i = 1; i <= 4; i++) push(4'(i), 22'(i), 2'd0);
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL txq_full: got %b want 0", tx_ready); end
        router_full = 1'b0;
        for (int i = 0; i < 10 && !ni_valid_out; i++) @(negedge clk);
        tests++; if (ni_valid_out !== 1'b1) begin fails++; $display("FAIL mid_send: got %b want 1", ni_valid_out); end
        rst_n = 1'b0;
        #1;
        tests++; if (ni_valid_out !== 1'b0) begin fails++; $display("FAIL mid_async_drop: got %b want 0", ni_valid_out); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ni_valid_out) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL mid_no_flits: got %0d want 0", seen); end
        tests++; if (tx_count !== 16'd0 || err_flags !== 3'b000) begin fails++; $display("FAIL mid_cleared: got count %0d err %b want 0 000", tx_count, err_flags); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b want 1", tx_ready); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_back_to_back();
        test_pressure();
        test_rx();
        test_rx_overflow();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
